switch_conditioner: RTL and testbench

//   Upstream front-end for OCPort: turns a raw, asynchronous, bouncing board switch

---
 rtl/switch_conditioner.sv | 98 +++++++++
 tb/tb_switch_conditioner.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/switch_conditioner.sv
// Raw board switch -> synchronised, debounced SwitchFlip level with edge pulses
// and a wrapping count of accepted toggles.
//
// state   | meaning
// STABLE  | sync2 agrees with SwitchFlip, nothing pending
// PENDING | sync2 disagrees with SwitchFlip, cnt holds the mismatch run length
module switch_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3,
  parameter int EVT_W           = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             SwitchRaw,
  output logic             SwitchFlip,
  output logic             RisePulse,
  output logic             FallPulse,
  output logic [EVT_W-1:0] ToggleCount
);

  localparam logic [0:0] STABLE  = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  localparam bit             ONE_SHOT = (DEBOUNCE_CYCLES == 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             accept;

  always_comb begin
    accept    = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      STABLE: begin
        if (sync2 != SwitchFlip) begin
          if (ONE_SHOT) begin
            accept  = 1'b1;
            cnt_nxt = '0;
          end else begin
            state_nxt = PENDING;
            cnt_nxt   = CNT_W'(1);
          end
        end else begin
          cnt_nxt = '0;
        end
      end
      PENDING: begin
        // A bounce back to the current level abandons the run; the next
        // mismatch restarts counting from 1.
        if (sync2 == SwitchFlip) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          accept    = 1'b1;
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = STABLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      state       <= STABLE;
      cnt         <= '0;
      SwitchFlip  <= 1'b0;
      RisePulse   <= 1'b0;
      FallPulse   <= 1'b0;
      ToggleCount <= '0;
    end else begin
      sync1     <= SwitchRaw;
      sync2     <= sync1;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      RisePulse <= accept & ~SwitchFlip;
      FallPulse <= accept & SwitchFlip;
      if (accept) begin
        SwitchFlip  <= ~SwitchFlip;
        ToggleCount <= ToggleCount + EVT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_switch_conditioner.sv
// Randomised and directed stimulus for switch_conditioner, checked every cycle
// against a sliding-window model of the debounce rule.
module tb_switch_conditioner;

  localparam int D = 4;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       SwitchRaw = 1'b0;
  logic       SwitchFlip;
  logic       RisePulse;
  logic       FallPulse;
  logic [7:0] ToggleCount;

  int checks = 0;
  int failures = 0;

  switch_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .EVT_W(8)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .SwitchRaw(SwitchRaw),
    .SwitchFlip(SwitchFlip),
    .RisePulse(RisePulse),
    .FallPulse(FallPulse),
    .ToggleCount(ToggleCount)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the level seen by the debouncer at edge n is the raw pin sampled at
  // edge n-2 (zero right after reset). A change is accepted at edge n exactly
  // when the last D such levels all differ from the current output level.
  bit       m_valid = 0;
  bit       m_flip, m_rise, m_fall;
  bit [7:0] m_cnt;
  bit       raw_q[$];
  bit       win[$];

  always @(posedge Clock) begin
    bit raw_s, rst_s, s, acc;
    raw_s = SwitchRaw;
    rst_s = Reset;
    if (rst_s) begin
      m_valid = 1;
      m_flip = 0; m_rise = 0; m_fall = 0; m_cnt = 0;
      raw_q.delete();
      win.delete();
    end else if (m_valid) begin
      s = (raw_q.size() == 2) ? raw_q[0] : 1'b0;
      raw_q.push_back(raw_s);
      if (raw_q.size() > 2) void'(raw_q.pop_front());
      win.push_back(s);
      if (win.size() > D) void'(win.pop_front());
      acc = (win.size() == D);
      foreach (win[i]) if (win[i] == m_flip) acc = 0;
      m_rise = acc && !m_flip;
      m_fall = acc && m_flip;
      if (acc) begin
        m_flip = !m_flip;
        m_cnt  = m_cnt + 8'd1;
      end
    end
    #1;
    if (m_valid) begin
      chk("flip", {31'b0, SwitchFlip}, {31'b0, m_flip});
      chk("rise", {31'b0, RisePulse}, {31'b0, m_rise});
      chk("fall", {31'b0, FallPulse}, {31'b0, m_fall});
      chk("count", {24'b0, ToggleCount}, {24'b0, m_cnt});
      chk("both_pulses", {31'b0, RisePulse & FallPulse}, 32'd0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic do_reset(input bit raw, input int n);
    @(negedge Clock);
    Reset = 1'b1;
    SwitchRaw = raw;
    cyc(n);
    chk("rst_flip", {31'b0, SwitchFlip}, 32'd0);
    chk("rst_count", {24'b0, ToggleCount}, 32'd0);
    chk("rst_pulses", {30'b0, RisePulse, FallPulse}, 32'd0);
    Reset = 1'b0;
  endtask

  initial begin
    // T1: reset with switch held high; rises 2 sync + D edges after release.
    do_reset(1'b1, 3);
    cyc(5);
    chk("t1_flip_early", {31'b0, SwitchFlip}, 32'd0);
    cyc(1);
    chk("t1_flip", {31'b0, SwitchFlip}, 32'd1);
    chk("t1_rise", {31'b0, RisePulse}, 32'd1);
    chk("t1_count", {24'b0, ToggleCount}, 32'd1);
    cyc(1);
    chk("t1_rise_end", {31'b0, RisePulse}, 32'd0);

    // T2: clean fall.
    SwitchRaw = 1'b0;
    cyc(5);
    chk("t2_flip_early", {31'b0, SwitchFlip}, 32'd1);
    cyc(1);
    chk("t2_flip", {31'b0, SwitchFlip}, 32'd0);
    chk("t2_fall", {31'b0, FallPulse}, 32'd1);
    chk("t2_count", {24'b0, ToggleCount}, 32'd2);

    // T3: bounce 1,0,1,0 then settle high.
    cyc(4);
    for (int i = 0; i < 4; i++) begin
      SwitchRaw = (i % 2 == 0);
      cyc(1);
    end
    SwitchRaw = 1'b1;
    cyc(5);
    chk("t3_flip_early", {31'b0, SwitchFlip}, 32'd0);
    cyc(1);
    chk("t3_flip", {31'b0, SwitchFlip}, 32'd1);
    chk("t3_count", {24'b0, ToggleCount}, 32'd3);

    // T4: low glitch of D-1 cycles is ignored, one of exactly D is accepted.
    cyc(3);
    SwitchRaw = 1'b0; cyc(D - 1);
    SwitchRaw = 1'b1; cyc(8);
    chk("t4_short_flip", {31'b0, SwitchFlip}, 32'd1);
    chk("t4_short_count", {24'b0, ToggleCount}, 32'd3);
    SwitchRaw = 1'b0; cyc(D);
    SwitchRaw = 1'b1; cyc(12);
    chk("t4_exact_flip", {31'b0, SwitchFlip}, 32'd1);
    chk("t4_exact_count", {24'b0, ToggleCount}, 32'd5);

    // T5: reset in the middle of a debounce run.
    SwitchRaw = 1'b0; cyc(8);
    SwitchRaw = 1'b1; cyc(3);
    do_reset(1'b1, 1);
    cyc(5);
    chk("t5_flip_early", {31'b0, SwitchFlip}, 32'd0);
    cyc(1);
    chk("t5_flip", {31'b0, SwitchFlip}, 32'd1);
    chk("t5_count", {24'b0, ToggleCount}, 32'd1);

    // Random bouncing with occasional resets.
    for (int p = 0; p < 500; p++) begin
      if ($urandom_range(0, 49) == 0) begin
        Reset = 1'b1;
        cyc($urandom_range(1, 2));
        Reset = 1'b0;
      end
      SwitchRaw = $urandom_range(0, 1);
      cyc($urandom_range(1, 9));
    end

    // T6: wrap of the toggle counter.
    do_reset(1'b0, 2);
    for (int t = 1; t <= 256; t++) begin
      SwitchRaw = ~SwitchRaw;
      cyc(8);
      if (t == 255) chk("t6_count_255", {24'b0, ToggleCount}, 32'd255);
    end
    chk("t6_count_wrap", {24'b0, ToggleCount}, 32'd0);
    chk("t6_flip", {31'b0, SwitchFlip}, 32'd0);

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
